spi_master_lcd: RTL and testbench

- SPI mode 0 master (CPOL=0, CPHA=0), MSB first; drives the LCD-side SPI slave in the same design and any compatible mode-0 device.
- Host side uses a start/busy/done handshake: one tx byte in, one rx byte out per frame.
- Generates SCK from clk with a programmable divider; drives SSEL active-low.
- Sits between the host controller and the SPI pins, in the same clock domain as the slave.

---
 rtl/spi_master_lcd.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_master_lcd.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_lcd.sv
// -----------------------------------------------------------------------------
// spi_master_lcd
//
// SPI mode 0 master (CPOL=0, CPHA=0), MSB first, one byte per frame.
// The host hands over a byte with a start/busy/done handshake. The block shifts
// the byte out on MOSI and returns the byte captured on MISO.
// SCK is produced from clk. Each SCK half-period lasts CLK_DIV clk cycles.
// Every frame ends with one CLK_DIV hold period with SSEL still low, followed
// by one CLK_DIV deselect gap, so any slave sees a minimum SSEL-high time.
//
// Parameter:
//   CLK_DIV     clk cycles per SCK half-period, 4..255. Four cycles is enough
//               for a slave that runs a 3-stage SCK synchroniser on the same clk.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high; aborts any frame at once
//   start       frame request, sampled only while busy=0
//   tx_data     byte to send, latched when start is accepted
//   rx_data     byte received on MISO, updated together with done
//   busy        frame or deselect gap in progress
//   done        one-cycle pulse when rx_data becomes valid
//   SCK         SPI clock, idles low
//   SSEL        slave select, active-low
//   MOSI        master data out, changes on SCK falling edges
//   MISO        slave data in, sampled where SCK is driven high
//
// Optional feature, compiled in when the macro SPI_MASTER_BURST_EN is defined:
//   hold_cs     latched with start. When it is 1, the frame ends with SSEL
//               still low, and the block waits in WAIT_NEXT for another byte.
//   release_cs  in WAIT_NEXT, ends the burst through HOLD/GAP with no done
//               pulse. ('release' itself is a reserved word.)
//   In WAIT_NEXT, start has priority over release_cs.
// -----------------------------------------------------------------------------
module spi_master_lcd #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
`ifdef SPI_MASTER_BURST_EN
  input  logic       hold_cs,
  input  logic       release_cs,
`endif
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  // Terminal count of the half-period divider.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW       = 3'd1,
    HIGH      = 3'd2,
    HOLD      = 3'd3,
`ifdef SPI_MASTER_BURST_EN
    GAP       = 3'd4,
    WAIT_NEXT = 3'd5
`else
    GAP       = 3'd4
`endif
  } state_t;

  state_t      state_r;
  logic [7:0]  div_cnt_r;
  logic [2:0]  bit_cnt_r;
  // MOSI already carries bit 7 at acceptance, so only the lower seven bits
  // of the transmit byte still have to be kept.
  logic [6:0]  tx_shift_r;
  logic [7:0]  rx_shift_r;
  logic        div_end_s;

`ifdef SPI_MASTER_BURST_EN
  logic        hold_cs_r;
  // Set when a burst is closed by release_cs. In that case the HOLD/GAP tail
  // carries no new data, so it must not raise done.
  logic        quiet_r;
`endif

  // The divider has reached the end of the current half-period / hold / gap.
  assign div_end_s = (div_cnt_r == DIV_LAST);

  // Frame sequencer: divider, bit counter, shift registers and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= 3'd7;
      tx_shift_r <= 7'd0;
      rx_shift_r <= 8'd0;
      rx_data    <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      SCK        <= 1'b0;
      SSEL       <= 1'b1;
      MOSI       <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      hold_cs_r  <= 1'b0;
      quiet_r    <= 1'b0;
`endif
    end else begin
      // done is a single-cycle strobe. Only the frame-completion branches raise it.
      done <= 1'b0;

      case (state_r)
        IDLE: begin
          div_cnt_r <= 8'd0;
          if (start) begin
            tx_shift_r <= tx_data[6:0];
            bit_cnt_r  <= 3'd7;
            MOSI       <= tx_data[7];
            SCK        <= 1'b0;
            SSEL       <= 1'b0;
            busy       <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            hold_cs_r  <= hold_cs;
            quiet_r    <= 1'b0;
`endif
            state_r    <= LOW;
          end
        end

        LOW: begin
          if (div_end_s) begin
            // Rising SCK edge. MISO is captured on the same clk edge, because
            // it has been stable since the previous falling edge.
            div_cnt_r  <= 8'd0;
            SCK        <= 1'b1;
            rx_shift_r <= {rx_shift_r[6:0], MISO};
            state_r    <= HIGH;
          end else begin
            div_cnt_r  <= div_cnt_r + 8'd1;
          end
        end

        HIGH: begin
          if (div_end_s) begin
            div_cnt_r <= 8'd0;
            SCK       <= 1'b0;
            if (bit_cnt_r != 3'd0) begin
              bit_cnt_r  <= bit_cnt_r - 3'd1;
              MOSI       <= tx_shift_r[6];
              tx_shift_r <= {tx_shift_r[5:0], 1'b0};
              state_r    <= LOW;
            end else begin
              // Last falling edge. MOSI keeps the final bit through the tail.
`ifdef SPI_MASTER_BURST_EN
              if (hold_cs_r) begin
                rx_data <= rx_shift_r;
                done    <= 1'b1;
                busy    <= 1'b0;
                state_r <= WAIT_NEXT;
              end else begin
                state_r <= HOLD;
              end
`else
              state_r <= HOLD;
`endif
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end

        HOLD: begin
          if (div_end_s) begin
            div_cnt_r <= 8'd0;
            SSEL      <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            if (!quiet_r) begin
              rx_data <= rx_shift_r;
              done    <= 1'b1;
            end
`else
            rx_data   <= rx_shift_r;
            done      <= 1'b1;
`endif
            state_r   <= GAP;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end

        GAP: begin
          if (div_end_s) begin
            div_cnt_r <= 8'd0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end

`ifdef SPI_MASTER_BURST_EN
        WAIT_NEXT: begin
          // SSEL stays low here. A new byte goes straight to LOW, and a
          // release goes through the normal deselect tail.
          div_cnt_r <= 8'd0;
          if (start) begin
            tx_shift_r <= tx_data[6:0];
            bit_cnt_r  <= 3'd7;
            MOSI       <= tx_data[7];
            busy       <= 1'b1;
            hold_cs_r  <= hold_cs;
            quiet_r    <= 1'b0;
            state_r    <= LOW;
          end else if (release_cs) begin
            busy       <= 1'b1;
            quiet_r    <= 1'b1;
            state_r    <= HOLD;
          end
        end
`endif

        default: begin
          // Unreachable encodings fall back to a safe, deselected idle.
          div_cnt_r <= 8'd0;
          bit_cnt_r <= 3'd7;
          SCK       <= 1'b0;
          SSEL      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_lcd.sv
// -----------------------------------------------------------------------------
// tb_spi_master_lcd
//
// Self-checking bench for spi_master_lcd with CLK_DIV=4.
// A behavioural mode-0 slave answers with a chosen byte. Optionally, MISO is
// looped back to MOSI. A negedge monitor logs the absolute clk cycle of every
// SCK rise (together with MOSI), every done pulse, every SSEL edge and every
// busy fall. Expected times and values come from the frame-level timing rules
// (bit n rises at (2n+1)*CLK_DIV, done at 17*CLK_DIV, and so on), measured
// from the accepting clk edge.
// -----------------------------------------------------------------------------
module tb_spi_master_lcd;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sck, ssel, mosi, miso;
`ifdef SPI_MASTER_BURST_EN
  logic       hold_cs = 1'b0;
  logic       release_cs = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_lcd #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_data(tx_data),
`ifdef SPI_MASTER_BURST_EN
    .hold_cs(hold_cs),
    .release_cs(release_cs),
`endif
    .rx_data(rx_data),
    .busy(busy),
    .done(done),
    .SCK(sck),
    .SSEL(ssel),
    .MOSI(mosi),
    .MISO(miso)
  );

  // Slave model state and monitor logs.
  logic       loopback = 1'b0;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_sh = 8'h00;
  logic       slv_bit = 1'b0;
  int         slv_cnt = 0;
  logic [7:0] slv_got[$];
  int         rise_t[$];
  logic       rise_b[$];
  int         done_t[$];
  logic [7:0] done_v[$];
  int         sfall_t[$];
  int         srise_t[$];
  int         bfall_t[$];
  logic       p_sck = 1'b0, p_ssel = 1'b1, p_busy = 1'b0;

  assign miso = loopback ? mosi : slv_bit;

  // Monitor plus mode-0 slave: present bit 7 at select, shift in on rise, next bit on fall.
  always @(negedge clk) begin
    if (!ssel && p_ssel) begin
      sfall_t.push_back(cyc);
      slv_cnt = 0;
      slv_bit = slv_tx[7];
    end
    if (ssel && !p_ssel) srise_t.push_back(cyc);
    if (sck && !p_sck) begin
      rise_t.push_back(cyc);
      rise_b.push_back(mosi);
      if (!ssel) begin
        slv_sh = {slv_sh[6:0], mosi};
        slv_cnt = slv_cnt + 1;
        if (slv_cnt % 8 == 0) slv_got.push_back(slv_sh);
      end
    end
    if (!sck && p_sck && !ssel) slv_bit = slv_tx[3'(7 - (slv_cnt % 8))];
    if (done) begin
      done_t.push_back(cyc);
      done_v.push_back(rx_data);
    end
    if (!busy && p_busy) bfall_t.push_back(cyc);
    p_sck = sck;
    p_ssel = ssel;
    p_busy = busy;
  end

  task automatic clear_mon();
    rise_t.delete(); rise_b.delete(); done_t.delete(); done_v.delete();
    sfall_t.delete(); srise_t.delete(); bfall_t.delete(); slv_got.delete();
  endtask

  // Present a byte with start for one cycle. t0 is the cycle number of the accepting edge.
  task automatic launch(input logic [7:0] tx, output int t0);
    @(negedge clk);
    tx_data = tx;
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_not_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 * CLK_DIV; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ssel !== 1'b1) begin n_bad++; $display("FAIL reset_ssel: got %b want 1", ssel); end
    n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck); end
    n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    rst = 1'b0;
    clear_mon();
    repeat (5) @(negedge clk);
    n_cmp++; if (rise_t.size() != 0 || ssel !== 1'b1) begin
      n_bad++; $display("FAIL idle_quiet: rises %0d ssel %b want 0 rises ssel 1", rise_t.size(), ssel);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] tx, sb;
    int t0;
    bit ok;
    for (int f = 0; f < 5; f++) begin
      tx = (f == 0) ? 8'hA5 : 8'($urandom);
      sb = (f == 0) ? 8'h3C : 8'($urandom);
      clear_mon();
      loopback = 1'b0;
      slv_tx = sb;
      launch(tx, t0);
      n_cmp++; if (ssel !== 1'b0 || busy !== 1'b1 || mosi !== tx[7]) begin
        n_bad++; $display("FAIL accept_outputs: ssel %b busy %b mosi %b want 0 1 %b", ssel, busy, mosi, tx[7]);
      end
      wait_not_busy(ok);
      repeat (3) @(negedge clk);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
      n_cmp++; if (rise_t.size() != 8) begin n_bad++; $display("FAIL basic_rises: got %0d want 8", rise_t.size()); end
      for (int n = 0; n < 8 && n < rise_t.size(); n++) begin
        n_cmp++; if (rise_t[n] - t0 != (2 * n + 1) * CLK_DIV) begin
          n_bad++; $display("FAIL rise_time bit%0d: got %0d want %0d", n, rise_t[n] - t0, (2 * n + 1) * CLK_DIV);
        end
        n_cmp++; if (rise_b[n] !== tx[3'(7 - n)]) begin
          n_bad++; $display("FAIL mosi_bit bit%0d: got %b want %b", n, rise_b[n], tx[3'(7 - n)]);
        end
      end
      n_cmp++; if (done_t.size() != 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", done_t.size()); end
      if (done_t.size() >= 1) begin
        n_cmp++; if (done_t[0] - t0 != 17 * CLK_DIV) begin
          n_bad++; $display("FAIL done_time: got %0d want %0d", done_t[0] - t0, 17 * CLK_DIV);
        end
        n_cmp++; if (done_v[0] !== sb) begin n_bad++; $display("FAIL rx_data: got %h want %h", done_v[0], sb); end
      end
      n_cmp++; if (srise_t.size() != 1 || (srise_t.size() == 1 && srise_t[0] - t0 != 17 * CLK_DIV)) begin
        n_bad++; $display("FAIL ssel_release: count %0d want 1 at %0d", srise_t.size(), 17 * CLK_DIV);
      end
      n_cmp++; if (bfall_t.size() != 1 || (bfall_t.size() == 1 && bfall_t[0] - t0 != 18 * CLK_DIV)) begin
        n_bad++; $display("FAIL busy_fall: count %0d want 1 at %0d", bfall_t.size(), 18 * CLK_DIV);
      end
      n_cmp++; if (slv_got.size() != 1 || (slv_got.size() == 1 && slv_got[0] !== tx)) begin
        n_bad++; $display("FAIL slave_byte: count %0d want 1 byte %h", slv_got.size(), tx);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] tx;
    int t0, rel;
    tx = 8'($urandom);
    slv_tx = 8'($urandom);
    loopback = 1'b0;
    clear_mon();
    launch(tx, t0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      start = (rel == 10 || rel == 70);
      if (rel == 10) tx_data = ~tx;
    end
    start = 1'b0;
    n_cmp++; if (sfall_t.size() != 1) begin n_bad++; $display("FAIL ignore_frames: got %0d want 1", sfall_t.size()); end
    n_cmp++; if (done_t.size() != 1) begin n_bad++; $display("FAIL ignore_done: got %0d want 1", done_t.size()); end
    n_cmp++; if (rise_t.size() != 8) begin n_bad++; $display("FAIL ignore_rises: got %0d want 8", rise_t.size()); end
    n_cmp++; if (slv_got.size() != 1 || (slv_got.size() == 1 && slv_got[0] !== tx)) begin
      n_bad++; $display("FAIL ignore_byte: count %0d want 1 byte %h", slv_got.size(), tx);
    end
    n_cmp++; if (rx_data !== slv_tx) begin n_bad++; $display("FAIL ignore_rx: got %h want %h", rx_data, slv_tx); end
  endtask

  task automatic test_back_to_back();
    int t0;
    bit saw_low, got2, ok;
    clear_mon();
    loopback = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    tx_data = 8'hFF;
    saw_low = 1'b0;
    got2 = 1'b0;
    for (int i = 0; i < 60 * CLK_DIV; i++) begin
      @(negedge clk);
      if (!busy) saw_low = 1'b1;
      else if (saw_low) begin
        got2 = 1'b1;
        break;
      end
    end
    start = 1'b0;
    tx_data = 8'($urandom);
    wait_not_busy(ok);
    repeat (3) @(negedge clk);
    n_cmp++; if (!got2 || !ok) begin n_bad++; $display("FAIL b2b_timeout: second %b idle %b want 1 1", got2, ok); end
    n_cmp++; if (done_v.size() != 2) begin n_bad++; $display("FAIL b2b_done: got %0d want 2", done_v.size()); end
    if (done_v.size() == 2) begin
      n_cmp++; if (done_v[0] !== 8'h00) begin n_bad++; $display("FAIL b2b_rx0: got %h want 00", done_v[0]); end
      n_cmp++; if (done_v[1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_rx1: got %h want ff", done_v[1]); end
    end
    n_cmp++; if (rise_t.size() != 16) begin n_bad++; $display("FAIL b2b_rises: got %0d want 16", rise_t.size()); end
    for (int n = 0; n < 16 && n < rise_b.size(); n++) begin
      n_cmp++; if (rise_b[n] !== (n >= 8)) begin
        n_bad++; $display("FAIL b2b_mosi rise%0d: got %b want %b", n, rise_b[n], n >= 8);
      end
    end
    if (sfall_t.size() == 2 && srise_t.size() >= 1) begin
      n_cmp++; if (sfall_t[1] - t0 != 18 * CLK_DIV + 1) begin
        n_bad++; $display("FAIL b2b_restart: got %0d want %0d", sfall_t[1] - t0, 18 * CLK_DIV + 1);
      end
      n_cmp++; if (sfall_t[1] - srise_t[0] < 4) begin
        n_bad++; $display("FAIL b2b_deselect: got %0d want >=4", sfall_t[1] - srise_t[0]);
      end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_ssel_edges: falls %0d rises %0d want 2 and >=1", sfall_t.size(), srise_t.size());
    end
  endtask

  task automatic test_loopback_random();
    logic [7:0] tx;
    int t0;
    bit ok;
    loopback = 1'b1;
    for (int f = 0; f < 4; f++) begin
      tx = 8'($urandom);
      clear_mon();
      launch(tx, t0);
      tx_data = 8'($urandom);
      wait_not_busy(ok);
      repeat (2) @(negedge clk);
      n_cmp++; if (!ok || rx_data !== tx) begin
        n_bad++; $display("FAIL loop_rx: got %h want %h (idle %b)", rx_data, tx, ok);
      end
    end
    loopback = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] tx;
    int t0, exp_rises;
    bit ok;
    loopback = 1'b0;
    slv_tx = 8'($urandom);
    clear_mon();
    launch(8'($urandom), t0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (ssel !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ssel: got %b want 1", ssel); end
    n_cmp++; if (sck !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sck: got %b want 0", sck); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rx: got %h want 00", rx_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_rises = 0;
    for (int n = 0; n < 8; n++) if ((2 * n + 1) * CLK_DIV <= 30) exp_rises++;
    n_cmp++; if (rise_t.size() != exp_rises || done_t.size() != 0) begin
      n_bad++; $display("FAIL mid_rst_edges: rises %0d done %0d want %0d 0", rise_t.size(), done_t.size(), exp_rises);
    end
    tx = 8'($urandom);
    slv_tx = 8'($urandom);
    clear_mon();
    launch(tx, t0);
    wait_not_busy(ok);
    repeat (3) @(negedge clk);
    n_cmp++; if (!ok || rx_data !== slv_tx || rise_t.size() != 8) begin
      n_bad++; $display("FAIL post_rst_frame: rx %h rises %0d want %h 8", rx_data, rise_t.size(), slv_tx);
    end
    n_cmp++; if (slv_got.size() != 1 || (slv_got.size() == 1 && slv_got[0] !== tx)) begin
      n_bad++; $display("FAIL post_rst_slave: count %0d want 1 byte %h", slv_got.size(), tx);
    end
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic test_burst();
    logic [7:0] b[3];
    int t0, tx0;
    bit ok;
    loopback = 1'b0;
    slv_tx = 8'($urandom);
    clear_mon();
    for (int k = 0; k < 3; k++) begin
      b[k] = 8'($urandom);
      hold_cs = (k < 2);
      launch(b[k], t0);
      if (k == 0) tx0 = t0;
      hold_cs = 1'b0;
      wait_not_busy(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_timeout byte%0d: busy %b want 0", k, busy); end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (rise_t.size() != 24) begin n_bad++; $display("FAIL burst_rises: got %0d want 24", rise_t.size()); end
    n_cmp++; if (sfall_t.size() != 1 || srise_t.size() != 1) begin
      n_bad++; $display("FAIL burst_ssel: falls %0d rises %0d want 1 1", sfall_t.size(), srise_t.size());
    end
    n_cmp++; if (done_v.size() != 3) begin n_bad++; $display("FAIL burst_done: got %0d want 3", done_v.size()); end
    for (int k = 0; k < 3 && k < done_v.size() && k < slv_got.size(); k++) begin
      n_cmp++; if (done_v[k] !== slv_tx || slv_got[k] !== b[k]) begin
        n_bad++; $display("FAIL burst_byte%0d: rx %h slave %h want %h %h", k, done_v[k], slv_got[k], slv_tx, b[k]);
      end
    end
    if (done_t.size() >= 1) begin
      n_cmp++; if (done_t[0] - tx0 != 16 * CLK_DIV) begin
        n_bad++; $display("FAIL burst_done_time: got %0d want %0d", done_t[0] - tx0, 16 * CLK_DIV);
      end
    end
    if (rise_t.size() == 24 && srise_t.size() == 1) begin
      n_cmp++; if (srise_t[0] - rise_t[23] != 2 * CLK_DIV) begin
        n_bad++; $display("FAIL burst_deselect: got %0d want %0d", srise_t[0] - rise_t[23], 2 * CLK_DIV);
      end
    end
  endtask

  task automatic test_release();
    int t0, r0;
    bit ok;
    slv_tx = 8'($urandom);
    clear_mon();
    hold_cs = 1'b1;
    launch(8'($urandom), t0);
    hold_cs = 1'b0;
    wait_not_busy(ok);
    @(negedge clk);
    release_cs = 1'b1;
    @(negedge clk);
    r0 = cyc;
    release_cs = 1'b0;
    repeat (3 * CLK_DIV) @(negedge clk);
    n_cmp++; if (done_t.size() != 1) begin n_bad++; $display("FAIL release_done: got %0d want 1", done_t.size()); end
    n_cmp++; if (srise_t.size() != 1 || (srise_t.size() == 1 && srise_t[0] - r0 != CLK_DIV)) begin
      n_bad++; $display("FAIL release_ssel: count %0d want 1 at %0d", srise_t.size(), CLK_DIV);
    end
    n_cmp++; if (busy !== 1'b0 || ssel !== 1'b1) begin
      n_bad++; $display("FAIL release_idle: busy %b ssel %b want 0 1", busy, ssel);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_ignore_start();
    test_back_to_back();
    test_loopback_random();
    test_reset_mid();
`ifdef SPI_MASTER_BURST_EN
    test_burst();
    test_release();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
